// File: rtl/evt_chk_pkg.sv
// Shared types and constants for the periodic-strobe interval checker.
// Holds the FSM state encoding, the error codes and a saturating increment helper.
package evt_chk_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        MEASURE,
        DONE_PASS,
        DONE_FAIL
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_FEW      = 2'd3;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/evt_interval_checker_if.sv
// Control pulses, monitored strobe and verdict outputs of the interval checker.
// The master side drives the pulses and strobe; the slave side is the checker.
interface evt_chk_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             check;
    logic             clear;
    logic             evt;
    logic [15:0]      evt_count;
    logic [CNT_W-1:0] last_interval;
    logic             busy;
    logic             pass;
    logic             fail;
    logic [1:0]       err_code;

    modport master (
        output start, check, clear, evt,
        input  evt_count, last_interval, busy, pass, fail, err_code
    );

    modport slave (
        input  start, check, clear, evt,
        output evt_count, last_interval, busy, pass, fail, err_code
    );
endinterface

// File: rtl/evt_edge_det.sv
// Rising-edge detector for the already-synchronous strobe.
// A level held high yields a single one-cycle rise.
module evt_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic evt,
    output logic evt_rise
);
    logic evt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) evt_q <= 1'b0;
        else        evt_q <= evt;
    end

    assign evt_rise = evt & ~evt_q;
endmodule

// File: rtl/evt_interval_checker.sv
// Measures cycles between strobe rises against an expected period and latches a PASS/FAIL verdict.
//   state     | meaning
//   IDLE      | outputs cleared, waiting for start
//   ARMED     | waiting for the first rise (no interval measured)
//   MEASURE   | counting cycles between rises, checking each interval
//   DONE_PASS | verdict latched: enough events, all intervals in tolerance
//   DONE_FAIL | verdict latched: err_code holds the reason
module evt_interval_checker
    import evt_chk_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 5,
    parameter int TOL        = 0,
    parameter int MIN_EVENTS = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    evt_chk_if.slave  bus
);
    localparam logic [CNT_W-1:0]      CNT_MAX = '1;
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic signed [CNT_W:0] EXP_S   = (CNT_W+1)'(EXP_PERIOD);
    localparam logic [CNT_W:0]        TOL_U   = (CNT_W+1)'(TOL);
    localparam logic [15:0]           MIN_EV  = 16'(MIN_EVENTS);

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        last_q, last_d;
    logic [15:0]             evc_q, evc_d;
    logic [1:0]              err_q, err_d;
    logic                    evt_rise;
    logic signed [CNT_W:0]   diff;
    logic [CNT_W:0]          mag;
    logic                    mismatch;
    logic                    cnt_sat;
    logic [15:0]             evc_inc;

    evt_edge_det u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .evt      (bus.evt),
        .evt_rise (evt_rise)
    );

    // One extra bit keeps the signed difference from wrapping for any legal period.
    assign diff     = $signed({1'b0, cnt_q}) - EXP_S;
    assign mag      = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
    assign mismatch = mag > TOL_U;
    assign cnt_sat  = (cnt_q == CNT_MAX);
    assign evc_inc  = sat_inc16(evc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            evc_q   <= '0;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            evc_q   <= evc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        evc_d   = evc_q;
        err_d   = err_q;
        if (bus.clear) begin
            state_d = IDLE;
            cnt_d   = '0;
            last_d  = '0;
            evc_d   = '0;
            err_d   = ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = ARMED;
                        cnt_d   = '0;
                        last_d  = '0;
                        evc_d   = '0;
                        err_d   = ERR_NONE;
                    end
                end
                ARMED: begin
                    if (evt_rise) begin
                        state_d = MEASURE;
                        evc_d   = 16'd1;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEASURE: begin
                    cnt_d = cnt_sat ? cnt_q : cnt_q + CNT_ONE;
                    // A rise is judged before check so a same-cycle check sees the updated count.
                    if (evt_rise) begin
                        last_d = cnt_q;
                        if (mismatch) begin
                            state_d = DONE_FAIL;
                            err_d   = ERR_MISMATCH;
                        end else begin
                            evc_d = evc_inc;
                            cnt_d = CNT_ONE;
                            if (bus.check) begin
                                state_d = (evc_inc >= MIN_EV) ? DONE_PASS : DONE_FAIL;
                                err_d   = (evc_inc >= MIN_EV) ? ERR_NONE : ERR_FEW;
                            end
                        end
                    end else if (cnt_sat) begin
                        state_d = DONE_FAIL;
                        err_d   = ERR_TIMEOUT;
                    end else if (bus.check) begin
                        state_d = (evc_q >= MIN_EV) ? DONE_PASS : DONE_FAIL;
                        err_d   = (evc_q >= MIN_EV) ? ERR_NONE : ERR_FEW;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.evt_count     = evc_q;
    assign bus.last_interval = last_q;
    assign bus.err_code      = err_q;
    assign bus.busy          = (state_q == ARMED) || (state_q == MEASURE);
    assign bus.pass          = (state_q == DONE_PASS);
    assign bus.fail          = (state_q == DONE_FAIL);
endmodule

// File: doc/evt_interval_checker.md
# evt_interval_checker

Self-checking consumer for a periodic strobe, such as one driven by a free-running `always` event generator. It sits directly downstream of the strobe source, detects rising edges, and measures the clock-cycle interval between consecutive edges against an expected period. It counts events and reports a sticky PASS/FAIL verdict with an error code, so benches can replace hand-written delay-and-compare checks with one instance.

## Interface
- `CNT_W`, default 8: interval counter width in bits; the counter saturates at 2^CNT_W-1.
- `EXP_PERIOD`, default 5: expected edge-to-edge interval in clock cycles; legal range 1..2^CNT_W-2.
- `TOL`, default 0: allowed absolute deviation from `EXP_PERIOD`, in cycles.
- `MIN_EVENTS`, default 2: minimum detected edges required for PASS.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `start  in  1`: one-cycle pulse; arms the checker from IDLE and is ignored in any other state.
- `check  in  1`: one-cycle pulse; requests a verdict and is ignored outside MEASURE.
- `clear  in  1`: synchronous return to IDLE from any state; clears all outputs.
- `evt  in  1`: monitored strobe, already synchronous to `clk`.
- `evt_count  out  16`: number of edges detected since arming; saturates at 16'hFFFF.
- `last_interval  out  CNT_W`: interval measured at the most recent edge.
- `busy  out  1`: high in ARMED or MEASURE.
- `pass  out  1`: sticky, high in DONE_PASS.
- `fail  out  1`: sticky, high in DONE_FAIL.
- `err_code  out  2`: 0 = none, 1 = interval mismatch, 2 = timeout (counter saturated), 3 = too few events at `check`.

## Operation
- Edge detect: `edge = evt & ~evt_q`, where `evt_q` is `evt` registered (reset value 0). An `evt` held high counts as one edge.
- **IDLE**
  - `start` → ARMED.
  - On this transition, `evt_count`, `last_interval` and `err_code` are zeroed.
  - `evt_q` keeps tracking, so `evt` already high at `start` does not produce an edge.
- **ARMED**
  - First edge → MEASURE, with `evt_count` = 1 and interval counter = 1.
  - No interval is checked on the first edge.
- **MEASURE**
  - Interval counter increments every cycle and saturates at all-ones.
  - On an edge:
    - compare the counter against `EXP_PERIOD`;
    - if |cnt − EXP_PERIOD| > TOL → DONE_FAIL with `err_code` = 1;
    - otherwise `evt_count`++ and the counter reloads to 1.
    - `last_interval` takes the counter value in both cases.
  - Counter reaches all-ones → DONE_FAIL with `err_code` = 2.
  - `check`:
    - `evt_count` ≥ MIN_EVENTS → DONE_PASS;
    - otherwise → DONE_FAIL with `err_code` = 3.
- **DONE_PASS / DONE_FAIL**: hold all outputs until `clear` or reset; `start` and `check` are ignored.
- Priority within a cycle: `clear` > error detection on an edge > `check`.
  - Edge and `check` in the same cycle: the edge is evaluated first. A mismatch gives FAIL code 1; otherwise the updated `evt_count` is used for the `check` decision.
  - Saturation and `check` in the same cycle: timeout (code 2) wins.
- Comparison is done in CNT_W+1 signed arithmetic, so no wrap occurs for any legal `EXP_PERIOD`/`TOL`.

## Timing
- Reset values: `evt_count` = 0, `last_interval` = 0, `busy` = 0, `pass` = 0, `fail` = 0, `err_code` = 0, state IDLE, `evt_q` = 0.
- Interval definition: `evt` rising at clock edges k and k+P (low in between) measures P.
- Edge-to-output latency is one cycle: `evt_count`, `last_interval` and `pass`/`fail` update on the same clock edge that samples the `evt` rise.
- `check` at edge k gives a verdict visible after edge k.
- `clear` at edge k gives IDLE and zeroed outputs after edge k.
- Reset asserted mid-measurement forces every output to its reset value immediately, with no clock needed.
- At the default `CNT_W` = 8, timeout fires 255 cycles after the last edge.

## Structure
- Package `evt_chk_pkg`:
  - state enum (IDLE, ARMED, MEASURE, DONE_PASS, DONE_FAIL);
  - `err_code` constants (ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_FEW).
- Sub-module `evt_edge_det` (clk, rst_n, evt → edge) holds the `evt_q` register.
- Interval counter, event counter and FSM stay in the top module.

## Test plan
- Reset, `start`, `evt` pulses every 5 cycles ×4, then `check` → `pass` = 1, `evt_count` = 4, `last_interval` = 5, `err_code` = 0.
- Third pulse arrives after 6 cycles (TOL = 0) → `fail` = 1, `err_code` = 1, `last_interval` = 6, `evt_count` = 2.
- One pulse, then `evt` held low 255 cycles → `fail` = 1, `err_code` = 2 exactly 255 cycles after the edge.
- One pulse then `check` (MIN_EVENTS = 2) → `fail` = 1, `err_code` = 3, `evt_count` = 1.
- `rst_n` low during MEASURE after 2 events → all outputs 0 immediately. Then `evt` held high across `start` → no edge counted until `evt` falls and rises again.
- Edge and `check` in the same cycle with a correct interval at `evt_count` = 1 → `pass`, `evt_count` = 2. `clear` together with an edge → IDLE, `evt_count` = 0.
